mux4_arbiter: RTL and testbench
===============================

# mux4_arbiter

Round-robin arbiter that shares one 4:1 multiplexer datapath among four requesters. Each requester raises a request; the arbiter grants one at a time, drives the mux select lines `s0`/`s1` for the granted input, and registers the selected data with a valid flag. It sits in front of the 4:1 mux resource and replaces static select wiring wherever several sources contend for one output.

## Interface

- `WIDTH`, 1: data width of each input and of `out`.
- `MAX_HOLD`, 4: maximum consecutive grant cycles for one requester while any other requester waits. Legal range is 1..15.

- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  request per source; `req[i]` belongs to `di`.
- `d0`..`d3`  input  WIDTH each  source data.
- `gnt`  output  4  one-hot grant, or all-zero when nothing is granted; registered.
- `s0`, `s1`  output  1 each  mux select; selected index = 2·`s1` + `s0`; registered.
- `out`  output  WIDTH  registered selected data.
- `valid`  output  1  `out` holds data from a granted source.

## Operation

- Reset, evaluated at a rising edge with `rst`=1, sets:
  - `gnt`=0000, `s0`=`s1`=0, `out`=0, `valid`=0.
  - Round-robin pointer `ptr`=0, hold counter `cnt`=0, state IDLE.
- `rst` takes priority over all other activity at that edge.

- **IDLE** (`gnt`=0000):
  - With `req`≠0, go to GRANT at the next edge.
  - The winner is the first set `req[i]` scanning `ptr`, `ptr`+1, … mod 4.
  - On entry to GRANT: `gnt`=one-hot(i), {`s1`,`s0`}=i, `cnt`=1.
- **GRANT**, holder h:
  - `req[h]`=0 and other requests pending: switch to the next winner, scanning from h+1 mod 4. `cnt`=1, with no idle cycle in between.
  - `req[h]`=0 and no other requests: return to IDLE. `gnt`=0000; `s0`/`s1` keep their last value.
  - `req[h]`=1, `cnt`=`MAX_HOLD`, and another request pending: switch to the next winner after h, `cnt`=1.
  - `req[h]`=1 otherwise: keep the grant. `cnt` increments, saturating at `MAX_HOLD`.
- Whenever a grant is issued to requester i, `ptr` is set to i+1 mod 4.
- Requests are level-sensitive. A requester must hold `req` until it sees its `gnt` bit; an unheld request may be lost.
- Datapath, at each edge:
  - `out` ← d[{`s1`,`s0`}] using the registered select from the previous cycle.
  - `valid` ← (`gnt`≠0).
  - When `valid` is 0, `out` keeps its last value.
- Widths: `cnt` is 4 bits and `ptr` is 2 bits; wrap-around from 3 to 0 is natural modulo 4.

## Timing

- Grant latency: `req` sampled high at edge N (arbiter idle) gives `gnt`/`s0`/`s1` valid after edge N.
- Data latency: `out`/`valid` lag `gnt` by one cycle. Data for a grant cycle appears after the following edge.
- Release latency: `req[h]` dropped before edge N removes or moves the grant after edge N.
- A held grant lasts at most `MAX_HOLD` cycles under contention. Worst-case wait for any requester is 3·`MAX_HOLD`+1 cycles.
- Simultaneous requests at the same edge are resolved by round-robin order from `ptr`; there is never more than one grant.
- Reset mid-grant forces all outputs to their reset values after that edge. The first grant after reset goes to the lowest-index active requester.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `req`=1111 → `gnt`=0000, `s0`=`s1`=0, `out`=0, `valid`=0. One edge after release: `gnt`=0001.
- **Single requester:** `req`=0100 held for 10 cycles → `gnt`=0100, `s1`=1, `s0`=0 throughout; no rotation. Drop `req` → `gnt`=0000 next edge.
- **Full contention:** `MAX_HOLD`=4, `req`=1111 held → grants 0001, 0010, 0100, 1000, 0001, … each for exactly 4 cycles, with no gaps.
- **Early release:** `req`=0011, requester 0 drops after 2 grant cycles → `gnt` moves to 0010 at the next edge with no idle cycle.
- **Datapath:** d0=1, d1=0, d2=0, d3=1, requesters granted in order 0,1,2,3 → `out` = 1, 0, 0, 1 with `valid`=1, each one cycle after the corresponding grant.
- **Reset mid-operation:** `rst` pulsed while `gnt`=1000 → all outputs reset after that edge. With `req`=1010 afterwards, the next grant is 0010.

Source files
------------

// File: rtl/mux4_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_arbiter
//
// Round-robin arbiter that shares one 4:1 multiplexer datapath among four
// requesters. One requester is granted at a time. The arbiter drives the
// registered mux select for that requester. The selected data is registered
// one cycle later, together with a valid flag.
//
// Parameters
//   WIDTH     data width of d0..d3 and out
//   MAX_HOLD  max consecutive grant cycles for one requester while another
//             requester waits (legal 1..15)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req[3:0]   level-sensitive request; req[i] belongs to di
//   d0..d3     source data
//   gnt[3:0]   registered one-hot grant (all-zero when idle)
//   s0, s1     registered mux select, index = 2*s1 + s0
//   out        registered selected data
//   valid      out holds data from a granted source
// -----------------------------------------------------------------------------
module mux4_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic             s0,
  output logic             s1,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q,   gnt_d;
  logic [1:0]       sel_q,   sel_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [3:0]       cnt_q,   cnt_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             valid_q, valid_d;

  logic [3:0]       others;
  logic             grant_now;
  logic [1:0]       win;
  logic [WIDTH-1:0] mux_data;

  // First set bit of r, scanning start, start+1, ... modulo 4. The loop runs
  // from the farthest offset down so that the nearest hit is the last to win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // The mux reads the select that is already registered. This keeps the
  // data one cycle behind the grant that chose it.
  always_comb begin
    case (sel_q)
      2'd0:    mux_data = d0;
      2'd1:    mux_data = d1;
      2'd2:    mux_data = d2;
      default: mux_data = d3;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so that no path through the
    // case leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_now = 1'b0;
    win       = 2'd0;
    // While in GRANT, gnt_q is one-hot of the holder, so this masks the holder out.
    others    = req & ~gnt_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_now = 1'b1;
          win       = rr_pick(req, ptr_q);
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (|others) begin
            // Hand over directly, with no idle cycle in between.
            grant_now = 1'b1;
            win       = rr_pick(others, sel_q + 2'd1);
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;   // select keeps its last value
          end
        end else if (cnt_q == MAX_HOLD_C && |others) begin
          grant_now = 1'b1;
          win       = rr_pick(others, sel_q + 2'd1);
        end else if (cnt_q != MAX_HOLD_C) begin
          cnt_d = cnt_q + 4'd1;  // saturates at MAX_HOLD
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_now) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      ptr_d   = win + 2'd1;
      cnt_d   = 4'd1;
    end

    valid_d = |gnt_q;
    out_d   = valid_d ? mux_data : out_q;
  end

  // NOTE: state is updated only with non-blocking assignments. All flops
  // then sample the values from before the edge, so the order of these
  // statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign s0    = sel_q[0];
  assign s1    = sel_q[1];
  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_arbiter
//
// Directed testbench for mux4_arbiter with WIDTH=1 and MAX_HOLD=4.
// The stimulus drives rst/req on the falling edge. It also queues the outputs
// the DUT should show after the next rising edge, tagged with that edge's
// number. A monitor on the falling edge pops the entries due for the current
// edge and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mux4_arbiter;

  typedef struct {
    int         tag;
    string      name;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       out;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [0:0] d0 = 1'b1, d1 = 1'b0, d2 = 1'b0, d3 = 1'b1;
  logic [3:0] gnt;
  logic       s0, s1;
  logic [0:0] out;
  logic       valid;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_pass  = 0;
  logic dval [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  mux4_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .s0(s0), .s1(s1), .out(out), .valid(valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req_v);
    n_check++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s @edge %0d: got %b, expected %b", name, cyc, act, req_v);
  endtask

  // Drive one cycle of stimulus, then queue the outputs expected after the next edge.
  task automatic tick(input string name, input logic r, input logic [3:0] rq,
                      input logic [3:0] eg, input logic [1:0] es,
                      input logic ev, input logic eo);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.tag = cyc + 1; e.name = name; e.gnt = eg; e.sel = es; e.valid = ev; e.out = eo;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation that is due at this edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.tag < cyc) begin
        n_check++;
        $display("FAIL %s stale: tag %0d, now edge %0d", e.name, e.tag, cyc);
      end else begin
        check({e.name, ".gnt"},   gnt,                 e.gnt);
        check({e.name, ".sel"},   {2'b00, s1, s0},     {2'b00, e.sel});
        check({e.name, ".valid"}, {3'b000, valid},     {3'b000, e.valid});
        check({e.name, ".out"},   {3'b000, out},       {3'b000, e.out});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for two edges with every requester active.
    tick("reset0", 1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    tick("reset1", 1, 4'b1111, 4'b0000, 2'd0, 0, 0);

    // Full contention: 0,1,2,3,0 for four cycles each, with no gaps. This also
    // covers the datapath order: out = 1,0,0,1 one cycle behind each grant.
    for (int k = 0; k < 20; k++) begin
      int g;
      g = (k / 4) % 4;
      if (k == 0)
        tick("contend", 0, 4'b1111, 4'b0001, 2'd0, 0, 0);
      else
        tick("contend", 0, 4'b1111, 4'b0001 << g, 2'(g), 1, dval[((k - 1) / 4) % 4]);
    end

    // Single requester 2 for 10 cycles: it takes over from 0 and never rotates.
    tick("single", 0, 4'b0100, 4'b0100, 2'd2, 1, 1);
    for (int k = 0; k < 9; k++)
      tick("single", 0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    tick("single_drop", 0, 4'b0000, 4'b0000, 2'd2, 1, 0);
    tick("idle",        0, 4'b0000, 4'b0000, 2'd2, 0, 0);

    // Early release. ptr=3, so scanning from 3 wraps to 0. Requester 0 drops
    // after 2 cycles and requester 1 takes over at once.
    tick("early0", 0, 4'b0011, 4'b0001, 2'd0, 0, 0);
    tick("early1", 0, 4'b0011, 4'b0001, 2'd0, 1, 1);
    tick("early2", 0, 4'b0010, 4'b0010, 2'd1, 1, 1);
    tick("early3", 0, 4'b0010, 4'b0010, 2'd1, 1, 0);
    tick("early4", 0, 4'b0000, 4'b0000, 2'd1, 1, 0);
    tick("early5", 0, 4'b0000, 4'b0000, 2'd1, 0, 0);

    // Reset mid-grant while gnt=1000. After release, req=1010 goes to 1.
    tick("mid0",   0, 4'b1000, 4'b1000, 2'd3, 0, 0);
    tick("mid1",   0, 4'b1000, 4'b1000, 2'd3, 1, 1);
    tick("midrst", 1, 4'b1000, 4'b0000, 2'd0, 0, 0);
    tick("post0",  0, 4'b1010, 4'b0010, 2'd1, 0, 0);
    tick("post1",  0, 4'b1010, 4'b0010, 2'd1, 1, 0);
    tick("post2",  0, 4'b1000, 4'b1000, 2'd3, 1, 0);

    // Lone holder saturates its counter. A new request then preempts it
    // immediately, and the scan from 3+1 wraps to 0.
    for (int k = 0; k < 5; k++)
      tick("sat", 0, 4'b1000, 4'b1000, 2'd3, 1, 1);
    tick("preempt", 0, 4'b1001, 4'b0001, 2'd0, 1, 1);
    tick("after",   0, 4'b0000, 4'b0000, 2'd0, 1, 1);
    tick("final",   0, 4'b0000, 4'b0000, 2'd0, 0, 1);

    // Allow the monitor to drain the queue.
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_check++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
